// File: rtl/axistream_unpack_pkg.sv
// Package: axistream_unpack_pkg
// Purpose: shared helpers for the AXI-Stream unpack stage.
//   elem_pos maps the beat number within a wide word (0 = first beat
//   emitted) to the element slot inside src_tdata, so that endian
//   ordering is decided in one place.
package axistream_unpack_pkg;

  // Slot of the element emitted on a given beat. In little-endian order,
  // beat k carries slot k. In big-endian order, the most significant slot
  // is emitted first.
  function automatic int unsigned elem_pos(input int unsigned beat,
                                           input int unsigned num_pack,
                                           input bit          big_endian);
    return big_endian ? (num_pack - 1 - beat) : beat;
  endfunction

endpackage

// File: rtl/axistream_unpack.sv
// Module: axistream_unpack
// Purpose: splits each wide AXI-Stream word of NUM_PACK elements into
//   NUM_PACK narrow beats. A single holding register keeps one word. The
//   final beat of a word may overlap the acceptance of the next word, so a
//   continuous stream runs at one narrow beat per cycle with no bubble.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   src_tvalid   wide word valid
//   src_tready   wide word accepted (combinational from dest_tready)
//   src_tdata    NUM_PACK elements; element i = [i*DATA_WIDTH +: DATA_WIDTH]
//   src_tlast    packet end; tags the last element emitted from this word
//   dest_tvalid  narrow beat valid
//   dest_tready  narrow beat accepted
//   dest_tdata   current element
//   dest_tlast   high on the final element of a word captured with tlast
module axistream_unpack
  import axistream_unpack_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PACK   = 4,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         src_tvalid,
  output logic                         src_tready,
  input  logic [DATA_WIDTH*NUM_PACK-1:0] src_tdata,
  input  logic                         src_tlast,
  output logic                         dest_tvalid,
  input  logic                         dest_tready,
  output logic [DATA_WIDTH-1:0]        dest_tdata,
  output logic                         dest_tlast
);

  localparam int IDX_W = $clog2(NUM_PACK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PACK - 1);

  logic [DATA_WIDTH*NUM_PACK-1:0] data_buf;
  logic                           last_buf;
  logic                           full;
  logic [IDX_W-1:0]               idx;

  logic on_last_beat;
  logic src_hs;
  logic dest_hs;

  assign on_last_beat = (idx == LAST_IDX);

  // The reset gating keeps both valid and ready low for the whole reset
  // window, including the time before the first clock edge.
  assign dest_tvalid = full && !rst;
  assign src_tready  = !rst && (!full || (on_last_beat && dest_tready));
  assign dest_tlast  = full && last_buf && on_last_beat;

  assign src_hs  = src_tvalid && src_tready;
  assign dest_hs = dest_tvalid && dest_tready;

  // A new word can only be accepted while the register is empty or while
  // its final beat leaves. So a load always takes priority and restarts
  // the beat counter. The counter wraps explicitly at the last element,
  // which also handles a NUM_PACK that is not a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_buf <= '0;
      last_buf <= 1'b0;
      full     <= 1'b0;
      idx      <= '0;
    end else if (src_hs) begin
      data_buf <= src_tdata;
      last_buf <= src_tlast;
      full     <= 1'b1;
      idx      <= '0;
    end else if (dest_hs) begin
      if (on_last_beat) begin
        full <= 1'b0;
        idx  <= '0;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  // Element select: each possible beat number drives its endian-mapped
  // slot when it matches the current counter value.
  always_comb begin
    dest_tdata = '0;
    for (int i = 0; i < NUM_PACK; i++) begin
      if (idx == IDX_W'(i)) begin
        dest_tdata = data_buf[elem_pos(i, NUM_PACK, BIG_ENDIAN)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_axistream_unpack.sv
// Testbench: tb_axistream_unpack
// Purpose: scoreboard bench for axistream_unpack. The bench drives three
//   instances:
//   - a little-endian 4x8 instance;
//   - a big-endian 4x8 instance that shares its inputs with the first;
//   - an independent 3x4 instance, driven from its own random process.
//   Each accepted word is turned into its expected beats by shift-and-mask
//   arithmetic and queued. A monitor per instance pops the queue and
//   compares on every output handshake.
module tb_axistream_unpack;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        rst3;

  logic        s_valid;
  logic [31:0] s_data;
  logic        s_last;
  logic        d_ready;

  logic        le_src_tready, le_dest_tvalid, le_dest_tlast;
  logic [7:0]  le_dest_tdata;
  logic        be_src_tready, be_dest_tvalid, be_dest_tlast;
  logic [7:0]  be_dest_tdata;

  logic        t_valid;
  logic [11:0] t_data;
  logic        t_last;
  logic        t_dready;
  logic        t_src_tready, t_dest_tvalid, t_dest_tlast;
  logic [3:0]  t_dest_tdata;

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  int dr_mode = 0;
  int accept_cycle = 0;
  int le_last_cycle = 0;
  bit done3 = 0;

  beat_t le_q[$];
  beat_t be_q[$];
  beat_t t_q[$];

  axistream_unpack #(.DATA_WIDTH(8), .NUM_PACK(4), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst(rst),
    .src_tvalid(s_valid), .src_tready(le_src_tready), .src_tdata(s_data), .src_tlast(s_last),
    .dest_tvalid(le_dest_tvalid), .dest_tready(d_ready), .dest_tdata(le_dest_tdata), .dest_tlast(le_dest_tlast)
  );

  axistream_unpack #(.DATA_WIDTH(8), .NUM_PACK(4), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst(rst),
    .src_tvalid(s_valid), .src_tready(be_src_tready), .src_tdata(s_data), .src_tlast(s_last),
    .dest_tvalid(be_dest_tvalid), .dest_tready(d_ready), .dest_tdata(be_dest_tdata), .dest_tlast(be_dest_tlast)
  );

  axistream_unpack #(.DATA_WIDTH(4), .NUM_PACK(3), .BIG_ENDIAN(1'b0)) dut_np3 (
    .clk(clk), .rst(rst3),
    .src_tvalid(t_valid), .src_tready(t_src_tready), .src_tdata(t_data), .src_tlast(t_last),
    .dest_tvalid(t_dest_tvalid), .dest_tready(t_dready), .dest_tdata(t_dest_tdata), .dest_tlast(t_dest_tlast)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it, and reports it when it differs.
  function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: element k of a word is (word >> k*width) masked.
  // Little-endian emits k = 0..n-1; big-endian emits k = n-1..0.
  // Only the final emitted beat inherits tlast.
  function automatic void pushWord(input logic [31:0] word, input logic last, input bit big);
    beat_t b;
    int k;
    for (int n = 0; n < 4; n++) begin
      k = big ? 3 - n : n;
      b.data = 8'((word >> (8 * k)) & 32'hFF);
      b.last = last && (n == 3);
      if (big) be_q.push_back(b);
      else le_q.push_back(b);
    end
  endfunction

  // One cycle of stimulus for the 4-wide pair. The inputs change on the
  // falling edge. Handshakes are sampled shortly before the rising edge.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic l, output bit acc);
    @(negedge clk);
    cycle++;
    s_valid = v;
    s_data  = d;
    s_last  = l;
    case (dr_mode)
      0:       d_ready = 1'b1;
      1:       d_ready = (cycle % 3 == 0);
      default: d_ready = ($urandom % 4 != 0);
    endcase
    #4;
    acc = v && le_src_tready;
    if (acc) pushWord(d, l, 1'b0);
    if (v && be_src_tready) pushWord(d, l, 1'b1);
  endtask

  task automatic sendWord(input logic [31:0] d, input logic l);
    bit acc = 0;
    int n = 0;
    while (!acc && n < 50) begin
      applyStimulus(1'b1, d, l, acc);
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("[TB] FAIL send_timeout: word %0h not accepted within 50 cycles", d);
    end
    accept_cycle = cycle;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, s_data, 1'b0, acc);
  endtask

  // Monitor for the little-endian instance. It also checks that data is
  // held steady across a stall.
  logic       le_stall = 0;
  logic [7:0] le_prev_data;
  logic       le_prev_last;
  always begin
    beat_t e;
    @(negedge clk);
    #4;
    if (le_stall && !rst) begin
      checkOutput("le_stall_valid", le_dest_tvalid, 1'b1);
      checkOutput("le_stall_data", le_dest_tdata, le_prev_data);
      checkOutput("le_stall_last", le_dest_tlast, le_prev_last);
    end
    if (le_dest_tvalid && d_ready) begin
      if (le_q.size() == 0) begin
        checkOutput("le_unexpected_beat", le_dest_tdata, 32'hDEAD);
      end else begin
        e = le_q.pop_front();
        checkOutput("le_data", le_dest_tdata, e.data);
        checkOutput("le_last", le_dest_tlast, e.last);
        if (le_dest_tlast) le_last_cycle = cycle;
      end
    end
    le_stall     = le_dest_tvalid && !d_ready;
    le_prev_data = le_dest_tdata;
    le_prev_last = le_dest_tlast;
  end

  // Monitor for the big-endian instance.
  always begin
    beat_t e;
    @(negedge clk);
    #4;
    if (be_dest_tvalid && d_ready) begin
      if (be_q.size() == 0) begin
        checkOutput("be_unexpected_beat", be_dest_tdata, 32'hDEAD);
      end else begin
        e = be_q.pop_front();
        checkOutput("be_data", be_dest_tdata, e.data);
        checkOutput("be_last", be_dest_tlast, e.last);
      end
    end
  end

  // Monitor for the three-element instance.
  always begin
    beat_t e;
    @(negedge clk);
    #4;
    if (t_dest_tvalid && t_dready) begin
      if (t_q.size() == 0) begin
        checkOutput("np3_unexpected_beat", t_dest_tdata, 32'hDEAD);
      end else begin
        e = t_q.pop_front();
        checkOutput("np3_data", t_dest_tdata, e.data);
        checkOutput("np3_last", t_dest_tlast, e.last);
      end
    end
  end

  // Independent random driver for the three-element instance. The first
  // word is a fixed 0x321 so that the wrap at element 2 is exercised
  // immediately.
  initial begin
    beat_t b;
    rst3 = 1'b1;
    t_valid = 1'b0; t_data = '0; t_last = 1'b0; t_dready = 1'b0;
    #3;
    checkOutput("np3_reset_src_tready", t_src_tready, 1'b0);
    checkOutput("np3_reset_dest_tvalid", t_dest_tvalid, 1'b0);
    repeat (3) @(negedge clk);
    rst3 = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (c < 4) begin
        t_valid = (c == 0); t_data = 12'h321; t_last = 1'b1; t_dready = 1'b1;
      end else begin
        t_valid  = ($urandom % 4 != 0);
        t_data   = 12'($urandom);
        t_last   = 1'($urandom);
        t_dready = ($urandom % 3 != 0);
      end
      #4;
      if (t_valid && t_src_tready) begin
        for (int k = 0; k < 3; k++) begin
          b.data = 8'((t_data >> (4 * k)) & 12'hF);
          b.last = t_last && (k == 2);
          t_q.push_back(b);
        end
      end
    end
    @(negedge clk);
    t_valid = 1'b0; t_dready = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("np3_drained", t_q.size(), 0);
    done3 = 1;
  end

  // Main sequence for the 4-wide pair.
  initial begin
    rst = 1'b1;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; d_ready = 1'b0;
    #3;
    checkOutput("reset_le_src_tready", le_src_tready, 1'b0);
    checkOutput("reset_le_dest_tvalid", le_dest_tvalid, 1'b0);
    checkOutput("reset_be_dest_tvalid", be_dest_tvalid, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_reset_src_tready", le_src_tready, 1'b1);
    checkOutput("post_reset_dest_tvalid", le_dest_tvalid, 1'b0);

    $display("[TB] single word, tlast set, continuous ready");
    dr_mode = 0;
    sendWord(32'h44332211, 1'b1);
    idle(6);
    $display("[TB] single word, tlast clear");
    sendWord(32'h44332211, 1'b0);
    idle(6);

    $display("[TB] back-to-back words");
    begin
      int c1;
      sendWord(32'h44332211, 1'b0);
      c1 = accept_cycle;
      sendWord(32'h88776655, 1'b1);
      checkOutput("bb_accept_gap", 32'(accept_cycle - c1), 4);
      idle(6);
      checkOutput("bb_last_beat_cycle", 32'(le_last_cycle - c1), 8);
    end

    $display("[TB] backpressure pattern");
    dr_mode = 1;
    sendWord(32'hA1B2C3D4, 1'b1);
    sendWord(32'h0F1E2D3C, 1'b0);
    idle(16);

    $display("[TB] reset mid-word");
    dr_mode = 0;
    sendWord(32'h44332211, 1'b1);
    idle(2);
    @(negedge clk);
    #2;
    checkOutput("pre_reset_dest_tvalid", le_dest_tvalid, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("async_reset_le_dest_tvalid", le_dest_tvalid, 1'b0);
    checkOutput("async_reset_be_dest_tvalid", be_dest_tvalid, 1'b0);
    checkOutput("async_reset_src_tready", le_src_tready, 1'b0);
    le_q.delete();
    be_q.delete();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("after_reset_src_tready", le_src_tready, 1'b1);
    checkOutput("after_reset_dest_tvalid", le_dest_tvalid, 1'b0);
    sendWord(32'hDDCCBBAA, 1'b1);
    idle(6);

    $display("[TB] random words and ready patterns");
    for (int w = 0; w < 200; w++) begin
      dr_mode = int'($urandom_range(0, 2));
      idle(int'($urandom_range(0, 2)));
      sendWord($urandom, 1'($urandom));
    end

    dr_mode = 0;
    begin
      int n = 0;
      while ((le_q.size() != 0 || be_q.size() != 0) && n < 100) begin
        idle(1);
        n++;
      end
    end
    idle(2);
    checkOutput("le_drained", le_q.size(), 0);
    checkOutput("be_drained", be_q.size(), 0);

    begin
      int n = 0;
      while (!done3 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      if (!done3) checkOutput("np3_finish_timeout", 32'(done3), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
